sel_mux_reg: RTL and testbench



---
 rtl/sel_mux_reg_if.sv | 27 ++
 rtl/sel_mux_reg.sv | 104 ++++++++++
 tb/tb_sel_mux_reg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sel_mux_reg_if.sv
// rtl/sel_mux_reg_if.sv - channel inputs, selection controls and registered output handshake of sel_mux_reg
interface sel_mux_reg_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 3
);
    localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [1:0]                mode;
    logic [SELW-1:0]           force_sel;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_sel;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, mode, force_sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, force_sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/sel_mux_reg.sv
// rtl/sel_mux_reg.sv - N-channel forced/priority/round-robin selector with a one-entry handshaked output register
module sel_mux_reg #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 3
) (
    input  logic         clk,
    input  logic         rst,
    sel_mux_reg_if.slave bus
);
    localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  sel_q;
    logic             valid_q;
    logic [SELW-1:0]  rr_ptr;

    logic             load_en;
    logic             grant_valid;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;
    int               best_dist;

    assign load_en = !valid_q || bus.out_ready;

    // Round-robin picks the valid channel with the smallest forward distance from rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        best_dist   = CHANNELS;
        case (bus.mode)
            2'b00: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (bus.force_sel == SELW'(i) && bus.in_valid[i]) begin
                        grant_valid = 1'b1;
                        grant       = SELW'(i);
                    end
                end
            end
            2'b10: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (bus.in_valid[i] &&
                        ((i + CHANNELS - int'(rr_ptr)) % CHANNELS) < best_dist) begin
                        best_dist   = (i + CHANNELS - int'(rr_ptr)) % CHANNELS;
                        grant_valid = 1'b1;
                        grant       = SELW'(i);
                    end
                end
            end
            default: begin
                for (int i = CHANNELS - 1; i >= 0; i--) begin
                    if (bus.in_valid[i]) begin
                        grant_valid = 1'b1;
                        grant       = SELW'(i);
                    end
                end
            end
        endcase
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Gated by rst so nothing is accepted during the cycle that discards state.
    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.in_ready[i] = !rst && load_en && grant_valid && (grant == SELW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            rr_ptr  <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                data_q  <= grant_data;
                sel_q   <= grant;
                valid_q <= 1'b1;
                if (bus.mode == 2'b10) begin
                    if (grant == SELW'(CHANNELS - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= grant + 1'b1;
                    end
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_sel_mux_reg.sv
// tb/tb_sel_mux_reg.sv - vector table, hand sequences and random run of sel_mux_reg against a reference model
module tb_sel_mux_reg;
    logic clk;
    logic rst;

    sel_mux_reg_if #(.WIDTH(32), .CHANNELS(3)) bus ();

    sel_mux_reg #(.WIDTH(32), .CHANNELS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         r;
        logic [2:0] v;
        logic [1:0] m;
        logic [1:0] fs;
        bit         ordy;
        logic [2:0] ir;
        bit         ov;
        logic [31:0] od;
        logic [1:0] os;
    } vec_t;

    vec_t tbl[20];

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    bit          m_valid = 0;
    logic [31:0] m_data  = 0;
    int          m_sel   = 0;
    int          m_rr    = 0;
    logic [2:0]  exp_ir;

    logic [2:0]  obs_ir;
    logic        obs_ov;
    logic [31:0] obs_od;
    logic [1:0]  obs_os;

    localparam logic [95:0] ABC = {32'hC, 32'hB, 32'hA};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ref_grant(input logic [2:0] v, input logic [1:0] m, input int fs, input int rr,
                             output bit gv, output int g);
        int c;
        gv = 0;
        g  = 0;
        if (m == 2'b00) begin
            if (fs < 3 && ((v >> fs) & 3'b001) != 0) begin
                gv = 1;
                g  = fs;
            end
        end else if (m == 2'b10) begin
            for (int j = 0; j < 3; j++) begin
                c = (rr + j) % 3;
                if (!gv && ((v >> c) & 3'b001) != 0) begin
                    gv = 1;
                    g  = c;
                end
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (!gv && ((v >> j) & 3'b001) != 0) begin
                    gv = 1;
                    g  = j;
                end
            end
        end
    endtask

    task automatic apply(input bit r, input logic [2:0] v, input logic [1:0] m, input logic [1:0] fs,
                         input bit ordy, input logic [95:0] d);
        bit gv;
        int g;
        bit load;
        rst           = r;
        bus.in_valid  = v;
        bus.mode      = m;
        bus.force_sel = fs;
        bus.out_ready = ordy;
        bus.in_data   = d;
        #1;
        obs_ir = bus.in_ready;
        load   = !m_valid || ordy;
        ref_grant(v, m, int'(fs), m_rr, gv, g);
        exp_ir = (!r && load && gv) ? 3'(1 << g) : 3'b000;
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_rr = 0;
        end else if (load) begin
            if (gv) begin
                m_valid = 1;
                m_data  = 32'(d >> (g * 32));
                m_sel   = g;
                if (m == 2'b10) m_rr = (g + 1) % 3;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        obs_ov = bus.out_valid;
        obs_od = bus.out_data;
        obs_os = bus.out_sel;
    endtask

    task automatic expect_now(input string tag, input logic [2:0] ir, input bit ov,
                              input logic [31:0] od, input logic [1:0] os);
        check({tag, ".in_ready"},  64'(obs_ir), 64'(ir));
        check({tag, ".out_valid"}, 64'(obs_ov), 64'(ov));
        check({tag, ".out_data"},  64'(obs_od), 64'(od));
        check({tag, ".out_sel"},   64'(obs_os), 64'(os));
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = '0; bus.mode = 2'b01; bus.force_sel = '0;
        bus.out_ready = 1'b0; bus.in_data = '0;

        // reset, priority, rr rotation/wrap, forced, out-of-range force, stall with mode change, reset
        tbl[0]  = '{1, 3'b111, 2'b01, 2'd0, 1, 3'b000, 0, 32'h0, 2'd0};
        tbl[1]  = '{1, 3'b111, 2'b01, 2'd0, 1, 3'b000, 0, 32'h0, 2'd0};
        tbl[2]  = '{0, 3'b111, 2'b01, 2'd0, 1, 3'b001, 1, 32'hA, 2'd0};
        tbl[3]  = '{0, 3'b111, 2'b01, 2'd0, 1, 3'b001, 1, 32'hA, 2'd0};
        tbl[4]  = '{0, 3'b111, 2'b10, 2'd0, 1, 3'b001, 1, 32'hA, 2'd0};
        tbl[5]  = '{0, 3'b111, 2'b10, 2'd0, 1, 3'b010, 1, 32'hB, 2'd1};
        tbl[6]  = '{0, 3'b111, 2'b10, 2'd0, 1, 3'b100, 1, 32'hC, 2'd2};
        tbl[7]  = '{0, 3'b111, 2'b10, 2'd0, 1, 3'b001, 1, 32'hA, 2'd0};
        tbl[8]  = '{0, 3'b111, 2'b10, 2'd0, 1, 3'b010, 1, 32'hB, 2'd1};
        tbl[9]  = '{0, 3'b100, 2'b10, 2'd0, 1, 3'b100, 1, 32'hC, 2'd2};
        tbl[10] = '{0, 3'b011, 2'b10, 2'd0, 1, 3'b001, 1, 32'hA, 2'd0};
        tbl[11] = '{0, 3'b111, 2'b00, 2'd2, 1, 3'b100, 1, 32'hC, 2'd2};
        tbl[12] = '{0, 3'b111, 2'b00, 2'd3, 1, 3'b000, 0, 32'hC, 2'd2};
        tbl[13] = '{0, 3'b111, 2'b00, 2'd3, 0, 3'b000, 0, 32'hC, 2'd2};
        tbl[14] = '{0, 3'b111, 2'b11, 2'd0, 0, 3'b001, 1, 32'hA, 2'd0};
        tbl[15] = '{0, 3'b010, 2'b01, 2'd0, 0, 3'b000, 1, 32'hA, 2'd0};
        tbl[16] = '{0, 3'b111, 2'b10, 2'd0, 0, 3'b000, 1, 32'hA, 2'd0};
        tbl[17] = '{0, 3'b111, 2'b10, 2'd0, 1, 3'b010, 1, 32'hB, 2'd1};
        tbl[18] = '{1, 3'b111, 2'b10, 2'd0, 1, 3'b000, 0, 32'h0, 2'd0};
        tbl[19] = '{0, 3'b111, 2'b10, 2'd0, 1, 3'b001, 1, 32'hA, 2'd0};

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].m, tbl[i].fs, tbl[i].ordy, ABC);
            expect_now($sformatf("vec%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].od, tbl[i].os);
        end

        // backpressure: 0x55 from channel 1 held through a 4-cycle stall, then refill with no bubble
        apply(0, 3'b010, 2'b01, 2'd0, 1, {32'hC, 32'h55, 32'hA});
        expect_now("bp_load", 3'b010, 1, 32'h55, 2'd1);
        for (int k = 0; k < 4; k++) begin
            apply(0, 3'b111, 2'b01, 2'd0, 0, {32'h33, 32'h22, 32'h11});
            expect_now($sformatf("bp_stall%0d", k), 3'b000, 1, 32'h55, 2'd1);
        end
        apply(0, 3'b111, 2'b01, 2'd0, 1, {32'h33, 32'h22, 32'h11});
        expect_now("bp_release", 3'b001, 1, 32'h11, 2'd0);

        // reset with a held word and every channel valid
        apply(0, 3'b111, 2'b01, 2'd0, 0, ABC);
        apply(1, 3'b111, 2'b01, 2'd0, 0, ABC);
        expect_now("rst_mid", 3'b000, 0, 32'h0, 2'd0);
        apply(0, 3'b111, 2'b10, 2'd0, 1, ABC);
        expect_now("rst_rr0", 3'b001, 1, 32'hA, 2'd0);

        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 39) == 0),
                  3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0),
                  {$urandom(), $urandom(), $urandom()});
            check("rnd.in_ready",  64'(obs_ir), 64'(exp_ir));
            check("rnd.out_valid", 64'(obs_ov), 64'(m_valid));
            if (m_valid) begin
                check("rnd.out_data", 64'(obs_od), 64'(m_data));
                check("rnd.out_sel",  64'(obs_os), 64'(m_sel));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
